// File: rtl/sisc_pkg.sv
// Shared widths and arbiter state encoding for the memory-arbiter slice.
package sisc_pkg;

    localparam int AW = 16;
    localparam int DW = 32;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GRANT_IF = 2'd1,
        GRANT_DM = 2'd2
    } state_t;

    // Bit positions in the two-way request/grant vectors.
    localparam int REQ_IF = 0;
    localparam int REQ_DM = 1;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory-side bundle of the memory arbiter.
interface mem_arbiter_if #(
    parameter int AW = sisc_pkg::AW,
    parameter int DW = sisc_pkg::DW
);
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic [DW-1:0] if_rdata;
    logic          if_valid;

    logic          dm_req;
    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic          dm_gnt;
    logic [DW-1:0] dm_rdata;
    logic          dm_valid;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    // Arbiter view.
    modport slave (
        input  if_req, if_addr,
        output if_gnt, if_rdata, if_valid,
        input  dm_req, dm_we, dm_addr, dm_wdata,
        output dm_gnt, dm_rdata, dm_valid,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    // Requesters and memory view.
    modport master (
        output if_req, if_addr,
        input  if_gnt, if_rdata, if_valid,
        output dm_req, dm_we, dm_addr, dm_wdata,
        input  dm_gnt, dm_rdata, dm_valid,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin pick; on a tie the requester not served last wins.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt_onehot
);
    // last: 1 = DM (bit 1) was served last, 0 = IF (bit 0) was served last.
    always_comb begin
        gnt_onehot = 2'b00;
        case (req)
            2'b01:   gnt_onehot = 2'b01;
            2'b10:   gnt_onehot = 2'b10;
            2'b11:   gnt_onehot = last ? 2'b01 : 2'b10;
            default: gnt_onehot = 2'b00;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates instruction-fetch and data-memory requests onto one memory port.
//   state    | meaning
//   IDLE     | no strobe; evaluate requests, capture winner
//   GRANT_IF | fetch strobe issued, if_gnt high
//   GRANT_DM | data strobe issued, dm_gnt high
module mem_arbiter #(
    parameter int AW = sisc_pkg::AW,
    parameter int DW = sisc_pkg::DW
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);
    import sisc_pkg::*;

    state_t        r_state;
    logic          r_last_dm;
    logic          r_if_gnt;
    logic          r_dm_gnt;
    logic          r_mem_en;
    logic          r_we;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic          r_if_valid;
    logic          r_dm_valid;
    logic [1:0]    w_gnt;

    rr_arb2 u_rr_arb2 (
        .req        ({bus.dm_req, bus.if_req}),
        .last       (r_last_dm),
        .gnt_onehot (w_gnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_last_dm  <= 1'b1;
            r_if_gnt   <= 1'b0;
            r_dm_gnt   <= 1'b0;
            r_mem_en   <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_if_valid <= 1'b0;
            r_dm_valid <= 1'b0;
        end else begin
            // Read data returns one cycle after the strobe; writes never pulse valid.
            r_if_valid <= (r_state == GRANT_IF);
            r_dm_valid <= (r_state == GRANT_DM) && !r_we;
            case (r_state)
                IDLE: begin
                    if (w_gnt[REQ_IF]) begin
                        r_state   <= GRANT_IF;
                        r_last_dm <= 1'b0;
                        r_if_gnt  <= 1'b1;
                        r_mem_en  <= 1'b1;
                        r_we      <= 1'b0;
                        r_addr    <= bus.if_addr;
                        r_wdata   <= '0;
                    end else if (w_gnt[REQ_DM]) begin
                        r_state   <= GRANT_DM;
                        r_last_dm <= 1'b1;
                        r_dm_gnt  <= 1'b1;
                        r_mem_en  <= 1'b1;
                        r_we      <= bus.dm_we;
                        r_addr    <= bus.dm_addr;
                        r_wdata   <= bus.dm_wdata;
                    end
                end
                GRANT_IF, GRANT_DM: begin
                    r_state  <= IDLE;
                    r_if_gnt <= 1'b0;
                    r_dm_gnt <= 1'b0;
                    r_mem_en <= 1'b0;
                end
                default: begin
                    r_state  <= IDLE;
                    r_if_gnt <= 1'b0;
                    r_dm_gnt <= 1'b0;
                    r_mem_en <= 1'b0;
                end
            endcase
        end
    end

    assign bus.if_gnt    = r_if_gnt;
    assign bus.dm_gnt    = r_dm_gnt;
    assign bus.if_valid  = r_if_valid;
    assign bus.dm_valid  = r_dm_valid;
    assign bus.if_rdata  = r_if_valid ? bus.mem_rdata : '0;
    assign bus.dm_rdata  = r_dm_valid ? bus.mem_rdata : '0;
    assign bus.mem_en    = r_mem_en;
    // Gating keeps the write enable confined to strobe cycles.
    assign bus.mem_we    = r_mem_en & r_we;
    assign bus.mem_addr  = r_addr;
    assign bus.mem_wdata = r_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a one-cycle-latency memory model.
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    mem_arbiter_if #(.AW(16), .DW(32)) bus ();

    mem_arbiter #(.AW(16), .DW(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [31:0] mem [0:255];

    always @(posedge clk) begin
        if (rst) begin
            mem[8'h10] <= 32'hDEADBEEF;
            mem[8'h30] <= 32'hCAFEF00D;
        end
        if (bus.mem_en && !bus.mem_we)
            bus.mem_rdata <= mem[bus.mem_addr[7:0]];
        if (bus.mem_en && bus.mem_we)
            mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.if_req   = 1'b0;
        bus.if_addr  = '0;
        bus.dm_req   = 1'b0;
        bus.dm_we    = 1'b0;
        bus.dm_addr  = '0;
        bus.dm_wdata = '0;
    endtask

    initial begin
        idle_inputs();
        bus.mem_rdata = '0;
        rst = 1'b1;
        tick();
        tick();
        chk("rst_mem_en", bus.mem_en, 0);
        chk("rst_if_gnt", bus.if_gnt, 0);
        chk("rst_dm_gnt", bus.dm_gnt, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);

        // Single fetch: gnt in cycle 2, valid with data in cycle 3.
        rst = 1'b0;
        bus.if_req  = 1'b1;
        bus.if_addr = 16'h0010;
        tick();
        chk("f_if_gnt", bus.if_gnt, 1);
        chk("f_mem_en", bus.mem_en, 1);
        chk("f_mem_we", bus.mem_we, 0);
        chk("f_mem_addr", bus.mem_addr, 32'h0010);
        chk("f_if_valid_early", bus.if_valid, 0);
        bus.if_req = 1'b0;
        tick();
        chk("f_if_valid", bus.if_valid, 1);
        chk("f_if_rdata", bus.if_rdata, 32'hDEADBEEF);
        chk("f_if_gnt_drop", bus.if_gnt, 0);
        chk("f_mem_en_idle", bus.mem_en, 0);

        // Simultaneous requests after reset: IF then DM two cycles later.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.if_req  = 1'b1;
        bus.if_addr = 16'h0010;
        bus.dm_req  = 1'b1;
        bus.dm_we   = 1'b0;
        bus.dm_addr = 16'h0030;
        tick();
        chk("t_if_gnt", bus.if_gnt, 1);
        chk("t_dm_gnt0", bus.dm_gnt, 0);
        bus.if_req = 1'b0;
        tick();
        chk("t_idle_en", bus.mem_en, 0);
        chk("t_idle_dm_gnt", bus.dm_gnt, 0);
        chk("t_if_valid", bus.if_valid, 1);
        tick();
        chk("t_dm_gnt", bus.dm_gnt, 1);
        chk("t_dm_addr", bus.mem_addr, 32'h0030);
        bus.dm_req = 1'b0;
        tick();
        chk("t_dm_valid", bus.dm_valid, 1);
        chk("t_dm_rdata", bus.dm_rdata, 32'hCAFEF00D);

        // Store then load back.
        bus.dm_req   = 1'b1;
        bus.dm_we    = 1'b1;
        bus.dm_addr  = 16'h0020;
        bus.dm_wdata = 32'h12345678;
        tick();
        chk("w_dm_gnt", bus.dm_gnt, 1);
        chk("w_mem_en", bus.mem_en, 1);
        chk("w_mem_we", bus.mem_we, 1);
        chk("w_mem_addr", bus.mem_addr, 32'h0020);
        chk("w_mem_wdata", bus.mem_wdata, 32'h12345678);
        idle_inputs();
        tick();
        chk("w_no_valid", bus.dm_valid, 0);
        chk("w_we_idle", bus.mem_we, 0);
        bus.dm_req  = 1'b1;
        bus.dm_we   = 1'b0;
        bus.dm_addr = 16'h0020;
        tick();
        chk("r_dm_gnt", bus.dm_gnt, 1);
        chk("r_mem_we", bus.mem_we, 0);
        idle_inputs();
        tick();
        chk("r_dm_valid", bus.dm_valid, 1);
        chk("r_dm_rdata", bus.dm_rdata, 32'h12345678);

        // Both held continuously: last served was DM, so IF leads and they alternate.
        bus.if_req  = 1'b1;
        bus.if_addr = 16'h0010;
        bus.dm_req  = 1'b1;
        bus.dm_we   = 1'b0;
        bus.dm_addr = 16'h0030;
        for (int c = 2; c <= 10; c++) begin
            tick();
            chk("rr_if_gnt", bus.if_gnt, ((c % 4) == 2) ? 1 : 0);
            chk("rr_dm_gnt", bus.dm_gnt, ((c % 4) == 0) ? 1 : 0);
            chk("rr_mem_en", bus.mem_en, ((c % 2) == 0) ? 1 : 0);
            chk("rr_if_valid", bus.if_valid, ((c % 4) == 3) ? 1 : 0);
            chk("rr_dm_valid", bus.dm_valid, ((c % 4) == 1) ? 1 : 0);
        end
        idle_inputs();
        tick();
        chk("rr_last_valid", bus.if_valid, 1);

        // Reset during GRANT_DM of a read kills the valid pulse.
        bus.dm_req  = 1'b1;
        bus.dm_we   = 1'b0;
        bus.dm_addr = 16'h0030;
        tick();
        chk("x_dm_gnt", bus.dm_gnt, 1);
        idle_inputs();
        rst = 1'b1;
        tick();
        chk("x_dm_valid", bus.dm_valid, 0);
        chk("x_dm_rdata", bus.dm_rdata, 0);
        chk("x_dm_gnt0", bus.dm_gnt, 0);
        chk("x_mem_en", bus.mem_en, 0);
        chk("x_mem_we", bus.mem_we, 0);
        chk("x_mem_addr", bus.mem_addr, 0);
        chk("x_mem_wdata", bus.mem_wdata, 0);
        chk("x_if_valid", bus.if_valid, 0);
        rst = 1'b0;
        bus.if_req  = 1'b1;
        bus.if_addr = 16'h0010;
        bus.dm_req  = 1'b1;
        bus.dm_addr = 16'h0030;
        tick();
        chk("x_tie_if", bus.if_gnt, 1);
        chk("x_tie_dm", bus.dm_gnt, 0);
        bus.if_req = 1'b0;
        tick();
        tick();
        chk("x_dm_after", bus.dm_gnt, 1);
        idle_inputs();
        tick();

        // DM raised during GRANT_IF: served two cycles after the fetch grant.
        bus.if_req  = 1'b1;
        bus.if_addr = 16'h0010;
        tick();
        chk("d_if_gnt", bus.if_gnt, 1);
        bus.if_req  = 1'b0;
        bus.dm_req  = 1'b1;
        bus.dm_we   = 1'b0;
        bus.dm_addr = 16'h0030;
        tick();
        chk("d_idle_dm_gnt", bus.dm_gnt, 0);
        chk("d_idle_en", bus.mem_en, 0);
        tick();
        chk("d_dm_gnt", bus.dm_gnt, 1);
        chk("d_dm_addr", bus.mem_addr, 32'h0030);
        idle_inputs();
        tick();
        chk("d_dm_valid", bus.dm_valid, 1);
        chk("d_dm_rdata", bus.dm_rdata, 32'hCAFEF00D);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters SHALL be: AW, 16, address width; DW, 32, data width.
REQ-002 clk  in  1  sole clock; all state updates on posedge clk.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 if_req  in  1  instruction-fetch read request; held high until if_gnt is seen.
REQ-005 if_addr  in  AW  fetch address; stable while if_req is high.
REQ-006 if_gnt  out  1  one-cycle pulse marking the cycle the fetch is issued to memory.
REQ-007 if_rdata  out  DW  fetch data; valid only while if_valid is high.
REQ-008 if_valid  out  1  one-cycle pulse, one cycle after if_gnt.
REQ-009 dm_req  in  1  data-memory request (LOD/STR); held high until dm_gnt is seen.
REQ-010 dm_we  in  1  1 = write (STR), 0 = read (LOD); stable while dm_req is high.
REQ-011 dm_addr  in  AW  data address; stable while dm_req is high.
REQ-012 dm_wdata  in  DW  store data; stable while dm_req is high.
REQ-013 dm_gnt  out  1  one-cycle pulse marking the cycle the data access is issued.
REQ-014 dm_rdata  out  DW  load data; valid only while dm_valid is high.
REQ-015 dm_valid  out  1  one-cycle pulse, one cycle after dm_gnt, reads only.
REQ-016 mem_en  out  1  memory access strobe.
REQ-017 mem_we  out  1  memory write enable; may be high only while mem_en is high.
REQ-018 mem_addr  out  AW  memory address.
REQ-019 mem_wdata  out  DW  memory write data.
REQ-020 mem_rdata  in  DW  memory read data, valid exactly one cycle after a read strobe.

Function
REQ-021 The FSM SHALL have states IDLE, GRANT_IF and GRANT_DM.
REQ-022 In IDLE with exactly one req high, the next state SHALL be the matching GRANT state.
REQ-023 In IDLE with both reqs high, the requester not served last SHALL win.
REQ-024 The last-served flag SHALL reset to "DM", so IF wins the first tie.
REQ-025 In IDLE, on the winning transition, the winner's addr/we/wdata SHALL be captured into registers.
REQ-026 mem_addr, mem_we and mem_wdata SHALL be driven only from the capture registers.
REQ-027 GRANT_IF SHALL drive: mem_en=1, mem_we=0, if_gnt=1.
REQ-028 GRANT_DM SHALL drive: mem_en=1, mem_we=captured dm_we, dm_gnt=1.
REQ-029 Each GRANT state SHALL last exactly one cycle, then return unconditionally to IDLE.
REQ-030 Sustained throughput SHALL be one access per 2 cycles.
REQ-031 A request arriving while in a GRANT state SHALL be evaluated in the following IDLE cycle.
REQ-032 if_valid or dm_valid (read only) SHALL pulse in the cycle after the GRANT.
REQ-033 The *_rdata output SHALL equal mem_rdata during its *_valid pulse.
REQ-034 A DM write SHALL produce no dm_valid pulse; the write completes at dm_gnt.
REQ-035 With both reqs held continuously, grants SHALL alternate IF, DM, IF, DM, ...
REQ-036 Maximum wait from req to gnt SHALL be 4 cycles.
REQ-037 Outside GRANT states: mem_en=0, mem_we=0, gnt=0.

Reset
REQ-038 While rst is high, the FSM SHALL go to IDLE on the next posedge.
REQ-039 On reset, all outputs, capture registers and valid pipelines SHALL clear to 0.
REQ-040 On reset, the last-served flag SHALL be set to DM.
REQ-041 If rst is asserted during a GRANT cycle, the pending valid pulse SHALL be suppressed.
REQ-042 No memory strobe SHALL be issued in the cycle following reset assertion.

Structure
REQ-043 AW, DW and the state encoding (IDLE=0, GRANT_IF=1, GRANT_DM=2) SHALL reside in the shared package sisc_pkg.
REQ-044 Two-way round-robin selection SHALL be a sub-module rr_arb2.
REQ-045 rr_arb2 ports SHALL be: req[1:0], last, gnt_onehot[1:0]; purely combinational.
REQ-046 All sequential logic SHALL reside in mem_arbiter.

Verification
REQ-047 The bench SHALL cover: after reset, if_req=1, if_addr=0x0010, memory 0x0010=0xDEADBEEF -> if_gnt at cycle 2, mem_addr=0x0010, mem_en=1 at cycle 2, if_valid at cycle 3 with if_rdata=0xDEADBEEF.
REQ-048 The bench SHALL cover: if_req and dm_req rising in the same cycle after reset -> IF granted first, DM granted 2 cycles later.
REQ-049 The bench SHALL cover: dm_req=1, dm_we=1, dm_addr=0x0020, dm_wdata=0x12345678 -> mem_we=1 with those values during dm_gnt; no dm_valid; a subsequent read of 0x0020 returns 0x12345678.
REQ-050 The bench SHALL cover: both reqs held for 10 cycles -> gnt sequence IF, DM, IF, DM, IF; no strobe in IDLE cycles.
REQ-051 The bench SHALL cover: rst pulsed during GRANT_DM of a read -> no dm_valid; next cycle IDLE; all outputs 0.
REQ-052 The bench SHALL cover: dm_req raised during GRANT_IF with if_req dropped -> dm_gnt exactly 2 cycles after if_gnt.
